n_bit_universal_shift_register: RTL
===================================

# n_bit_universal_shift_register

Parametrised N-bit universal shift register with asynchronous active-low reset. It supports hold, parallel load, logical and arithmetic shifts, rotates, clear, and a multi-cycle burst shift with a busy/done handshake. It replaces fixed-function registers wherever a datapath needs serialisation, alignment or rotate-by-k without a barrel shifter.

## Interface
- N, default 4: register width, N >= 2.
- AW, default $clog2(N)+1: width of the burst amount; must hold the value N.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  clock enable; when low, no state changes except the done clear.
- mode  input  3  operation: 000 hold, 001 load d, 010 shl, 011 shr, 100 rol, 101 ror, 110 ashr, 111 clear.
- start  input  1  with en, starts a burst of mode repeated amt times.
- amt  input  AW  burst repeat count, sampled on an accepted start.
- d  input  N  parallel load data.
- sin_r  input  1  serial in to bit 0 on shl.
- sin_l  input  1  serial in to bit N-1 on shr.
- q  output  N  register contents.
- sout_l  output  1  equals q[N-1].
- sout_r  output  1  equals q[0].
- busy  output  1  high while a burst has shifts remaining.
- done  output  1  one-cycle pulse when an accepted start completes.

## Operation
- Reset (rst=0, asynchronous): q=0, busy=0, done=0, internal count=0. Exits on the first clk edge after rst=1.
- Single-step (IDLE, en=1, start=0): on each edge apply mode.
  - shl: q <= {q[N-2:0], sin_r}.
  - shr: q <= {sin_l, q[N-1:1]}.
  - rol: q <= {q[N-2:0], q[N-1]}.
  - ror: q <= {q[0], q[N-1:1]}.
  - ashr: q <= {q[N-1], q[N-1:1]}.
  - clear: q <= 0.
  - load: q <= d.
  - hold: q unchanged.
- States:
  - IDLE (busy=0).
  - BURST (busy=1). The latched mode and remaining count are held here.
- Accepted start (IDLE, en=1, start=1):
  - Shift/rotate mode (010-110), amt >= 1: the first step executes on the accepting edge. The mode is latched and remaining = amt-1.
    - If amt=1: stay in IDLE and set done=1.
    - Else: go to BURST.
  - amt=0: q unchanged, done=1, stay in IDLE.
  - Non-shift mode (000, 001, 111): execute the op once and set done=1. amt is ignored.
- BURST, per edge:
  - If en=1: apply the latched mode and decrement remaining. When remaining reaches 0, go to IDLE with done=1.
  - If en=0: stall. q, remaining and busy all hold.
- While in BURST, the mode, start, d and amt inputs are ignored. sin_r and sin_l are sampled on every executed step.
- done is a registered pulse, high for exactly one cycle, then cleared on the next edge regardless of en.
- A start may be issued in the cycle where done=1, because the block is already in IDLE.
- amt > N is legal. The burst runs amt steps: rotates wrap modulo N, and shifts fill entirely with serial input or sign.

## Timing
- Single-step latency: q is updated 1 edge after it is sampled.
- A burst of k >= 1 steps with en held high:
  - Step i executes at edge E0+i-1.
  - busy is high from after E0 until after E0+k-1, i.e. for k-1 cycles.
  - done is high during the cycle after edge E0+k-1.
- Each stall cycle (en=0) adds 1 cycle to busy.
- sout_l and sout_r are combinational from q. There is no added latency.
- Reset mid-burst takes effect immediately: q=0, busy=0, done=0, and the burst is abandoned.

## Test plan
- Reset and load, N=4:
  - Hold rst=0 -> q=0000, busy=0, done=0.
  - Release rst, then en=1, mode=001, d=1010 -> q=1010 after 1 edge.
- Single-step modes on q=1001:
  - shl with sin_r=1 -> 0011.
  - shr with sin_l=0 -> 0100.
  - rol -> 0011.
  - ror -> 1100.
  - ashr -> 1100.
  - clear -> 0000.
- Burst rol, amt=3, q=0001, en high:
  - q goes 0010, 0100, 1000 on successive edges.
  - busy is high for 2 cycles.
  - done pulses once after the third edge.
- Burst with stall: shr, amt=2, q=1111, sin_l=0, en=0 for one cycle mid-burst:
  - q=0111, then holds 0111 during the stall, then 0011.
  - busy is high for 2 cycles; done follows.
- Edge cases:
  - start with amt=0 -> q unchanged, done pulses, busy stays 0.
  - start with mode=001 -> loads d, done pulses.
  - A back-to-back start in the done cycle is accepted.
- Asynchronous reset mid-burst: rol with amt=4, assert rst=0 between edges after step 2:
  - q=0000 and busy=0 immediately, with no clock.
  - No done pulse after release.

Source files
------------

// File: rtl/n_bit_universal_shift_register.sv
// Universal N-bit shift register: hold, load, shifts, rotates, clear,
// plus multi-cycle burst shift with busy/done handshake.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-low reset
//   en      clock enable (done still clears when low)
//   mode    000 hold, 001 load, 010 shl, 011 shr,
//           100 rol, 101 ror, 110 ashr, 111 clear
//   start   with en, begins a burst of mode repeated amt times
//   amt     burst repeat count, sampled on accepted start
//   d       parallel load data
//   sin_r   serial in to bit 0 on shl
//   sin_l   serial in to bit N-1 on shr
//   q       register contents
//   sout_l  q[N-1]
//   sout_r  q[0]
//   busy    burst has steps remaining
//   done    one-cycle pulse when an accepted start completes
module n_bit_universal_shift_register #(
  parameter int N  = 4,
  parameter int AW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [2:0]    mode,
  input  logic          start,
  input  logic [AW-1:0] amt,
  input  logic [N-1:0]  d,
  input  logic          sin_r,
  input  logic          sin_l,
  output logic [N-1:0]  q,
  output logic          sout_l,
  output logic          sout_r,
  output logic          busy,
  output logic          done
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_LOAD  = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_SHR   = 3'b011;
  localparam logic [2:0] M_ROL   = 3'b100;
  localparam logic [2:0] M_ROR   = 3'b101;
  localparam logic [2:0] M_ASHR  = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  state_t          state_q, state_d;
  logic [N-1:0]    q_q, q_d;
  logic [2:0]      mode_q, mode_d;
  logic [AW-1:0]   rem_q, rem_d;
  logic            done_q, done_d;
  logic            is_shift;

  function automatic logic [N-1:0] step(
    input logic [2:0]   m,
    input logic [N-1:0] v,
    input logic [N-1:0] ld,
    input logic         sr,
    input logic         sl
  );
    logic [N-1:0] r;
    r = v;
    case (m)
      M_HOLD:  r = v;
      M_LOAD:  r = ld;
      M_SHL:   r = {v[N-2:0], sr};
      M_SHR:   r = {sl, v[N-1:1]};
      M_ROL:   r = {v[N-2:0], v[N-1]};
      M_ROR:   r = {v[0], v[N-1:1]};
      M_ASHR:  r = {v[N-1], v[N-1:1]};
      M_CLEAR: r = '0;
      default: r = v;
    endcase
    return r;
  endfunction

  assign is_shift = (mode >= M_SHL) && (mode <= M_ASHR);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          if (start && is_shift) begin
            // first step runs on the accepting edge
            if (amt != '0) begin
              q_d    = step(mode, q_q, d, sin_r, sin_l);
              mode_d = mode;
              rem_d  = amt - AW'(1);
              if (amt == AW'(1)) begin
                done_d = 1'b1;
              end else begin
                state_d = BURST;
              end
            end else begin
              done_d = 1'b1;
            end
          end else begin
            q_d    = step(mode, q_q, d, sin_r, sin_l);
            done_d = start;
          end
        end
      end
      BURST: begin
        if (en) begin
          q_d   = step(mode_q, q_q, d, sin_r, sin_l);
          rem_d = rem_q - AW'(1);
          if (rem_q == AW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      mode_q  <= M_HOLD;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  assign q      = q_q;
  assign sout_l = q_q[N-1];
  assign sout_r = q_q[0];
  assign busy   = (state_q == BURST);
  assign done   = done_q;

endmodule
